multi_channel_threshold_counter: RTL and testbench
==================================================

// Module: multi_channel_threshold_counter
// PURPOSE
//  CHANNELS independent up-counters for the timer/control input path. Each channel
//  raises a sticky 'reached' flag when its count reaches THRESHOLD, then either
//  saturates at MAX_COUNT (one-shot) or wraps to 0 (recycling), selected per channel.
//  Each channel also supports count-enable and parallel load.
//  With defaults, enable=1 and recycle=0, one channel forms a 3-bit saturating
//  counter whose flag rises with count 4.
// PARAMETERS
//  CHANNELS   1  number of independent counter channels (>=1)
//  WIDTH      3  counter width in bits per channel
//  THRESHOLD  4  count value at which reached sets (1..MAX_COUNT)
//  MAX_COUNT  7  terminal count; must be <= 2**WIDTH-1
// PORTS
//  clock       in   1               rising-edge clock, only clock domain
//  clear_n     in   1               synchronous active-low reset
//  enable      in   CHANNELS        per-channel count enable
//  recycle     in   CHANNELS        per-channel mode: 0 saturate at MAX_COUNT, 1 wrap to 0
//  load        in   CHANNELS        per-channel parallel load strobe
//  load_value  in   CHANNELS*WIDTH  load data; channel i = [i*WIDTH +: WIDTH]
//  count       out  CHANNELS*WIDTH  current count per channel (registered)
//  reached     out  CHANNELS        sticky flag: count >= THRESHOLD since last clear/wrap/load
//  hit_pulse   out  CHANNELS        1-cycle pulse on the increment that reaches THRESHOLD
//  wrap_pulse  out  CHANNELS        1-cycle pulse when a recycling channel wraps to 0
//  at_max      out  CHANNELS        registered: count == MAX_COUNT
// BEHAVIOUR
//  - All outputs are registered and update only on the clock rising edge.
//  - clear_n=0 at an edge: every count, reached, hit_pulse, wrap_pulse and at_max go to 0.
//    This overrides load and enable, including mid-count.
//  - Per-channel priority, evaluated at each edge: clear_n=0 > load > enable.
//  - load[i]=1:
//    - count <= min(load_value_i, MAX_COUNT); an out-of-range value is clamped.
//    - reached <= (loaded value >= THRESHOLD).
//    - hit_pulse and wrap_pulse <= 0.
//  - enable[i]=1, load[i]=0, count < MAX_COUNT:
//    - count <= count+1.
//    - If count+1 == THRESHOLD, hit_pulse <= 1 and reached <= 1.
//  - enable[i]=1, count == MAX_COUNT, recycle[i]=0: count holds; reached holds; no pulses.
//  - enable[i]=1, count == MAX_COUNT, recycle[i]=1: count <= 0, reached <= 0, wrap_pulse <= 1.
//    - If THRESHOLD == MAX_COUNT, the hit and wrap pulses fall on different cycles.
//  - enable[i]=0 and load[i]=0: count and reached hold; hit_pulse and wrap_pulse <= 0.
//  - hit_pulse and wrap_pulse are never high for two consecutive cycles without a new event.
//  - recycle is sampled only at the terminal edge. Changing recycle while a channel
//    sits saturated lets that channel wrap on its next enabled edge.
//  - Channels are fully independent; simultaneous events on different channels do not interact.
//  - Latency: one clock from enable/load to count, flags and pulses.
//  - Arithmetic is unsigned WIDTH-bit. No overflow is possible because count <= MAX_COUNT.
// TESTING
//  1. Defaults, clear_n=0 for 2 cycles, then enable=1, recycle=0 for 10 cycles
//     -> count 1..7 then holds 7; reached and hit_pulse rise with count=4
//     (hit_pulse high 1 cycle); at_max=1 from count=7; no wrap_pulse.
//  2. recycle=1, enable=1 for 9 cycles -> count 1..7,0,1; wrap_pulse=1 only with count=0;
//     reached drops to 0 with count=0; hit_pulse fires again on the next pass.
//  3. load=1 with load_value=5 -> next edge count=5, reached=1, hit_pulse=0;
//     then load_value=2 -> count=2, reached=0.
//  4. load and enable together at count=3 -> load wins: count=load_value, no hit_pulse.
//     load_value > MAX_COUNT (WIDTH=4, MAX_COUNT=9, load 15) -> count=9.
//  5. clear_n=0 at count=5 with enable=1 and load=1 -> next edge: all outputs 0.
//     enable toggled 1/0 -> count advances only on enabled edges.
//  6. CHANNELS=3: ch0 saturating, ch1 recycling, ch2 loaded mid-run
//     -> each channel matches an independent reference model; no cross-talk.

Source files
------------

// File: rtl/multi_channel_threshold_counter_if.sv
// Control/status bundle for the multi-channel threshold counter.
// master drives the per-channel controls; slave (the counter) returns status.
interface multi_channel_threshold_counter_if #(
   parameter int CHANNELS = 1,
   parameter int WIDTH    = 3
);
   logic [CHANNELS-1:0]       enable;
   logic [CHANNELS-1:0]       recycle;
   logic [CHANNELS-1:0]       load;
   logic [CHANNELS*WIDTH-1:0] load_value;
   logic [CHANNELS*WIDTH-1:0] count;
   logic [CHANNELS-1:0]       reached;
   logic [CHANNELS-1:0]       hit_pulse;
   logic [CHANNELS-1:0]       wrap_pulse;
   logic [CHANNELS-1:0]       at_max;

   modport master (
      output enable, recycle, load, load_value,
      input  count, reached, hit_pulse, wrap_pulse, at_max
   );

   modport slave (
      input  enable, recycle, load, load_value,
      output count, reached, hit_pulse, wrap_pulse, at_max
   );
endinterface

// File: rtl/multi_channel_threshold_counter.sv
// Independent per-channel up-counters with sticky threshold flag, saturate or
// wrap at MAX_COUNT, parallel load (clamped) and count enable.

// One counter channel; priority clear > load > enable.
module multi_channel_threshold_counter_lane #(
   parameter int WIDTH     = 3,
   parameter int THRESHOLD = 4,
   parameter int MAX_COUNT = 7
) (
   input  logic             clock_i,
   input  logic             clear_n_i,
   input  logic             enable_i,
   input  logic             recycle_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   output logic [WIDTH-1:0] count_o,
   output logic             reached_o,
   output logic             hit_pulse_o,
   output logic             wrap_pulse_o,
   output logic             at_max_o
);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] THR_C = WIDTH'(THRESHOLD);

   logic [WIDTH-1:0] count_q, count_d;
   logic             reached_q, reached_d;
   logic             hit_q, hit_d;
   logic             wrap_q, wrap_d;
   logic             at_max_q, at_max_d;

   // Next-state: pulses default low so they never stretch past their event.
   always_comb begin
      count_d   = count_q;
      reached_d = reached_q;
      hit_d     = 1'b0;
      wrap_d    = 1'b0;
      if (load_i) begin
         count_d   = (load_value_i > MAX_C) ? MAX_C : load_value_i;
         reached_d = (count_d >= THR_C);
      end else if (enable_i) begin
         if (count_q < MAX_C) begin
            count_d = count_q + WIDTH'(1);
            if (count_d == THR_C) begin
               hit_d     = 1'b1;
               reached_d = 1'b1;
            end
         end else if (recycle_i) begin
            count_d   = '0;
            reached_d = 1'b0;
            wrap_d    = 1'b1;
         end
      end
      at_max_d = (count_d == MAX_C);
   end

   // State register with synchronous active-low clear.
   always_ff @(posedge clock_i) begin
      if (!clear_n_i) begin
         count_q   <= '0;
         reached_q <= 1'b0;
         hit_q     <= 1'b0;
         wrap_q    <= 1'b0;
         at_max_q  <= 1'b0;
      end else begin
         count_q   <= count_d;
         reached_q <= reached_d;
         hit_q     <= hit_d;
         wrap_q    <= wrap_d;
         at_max_q  <= at_max_d;
      end
   end

   assign count_o      = count_q;
   assign reached_o    = reached_q;
   assign hit_pulse_o  = hit_q;
   assign wrap_pulse_o = wrap_q;
   assign at_max_o     = at_max_q;
endmodule

module multi_channel_threshold_counter #(
   parameter int CHANNELS  = 1,
   parameter int WIDTH     = 3,
   parameter int THRESHOLD = 4,
   parameter int MAX_COUNT = 7
) (
   input  logic                             clock_i,
   input  logic                             clear_n_i,
   multi_channel_threshold_counter_if.slave bus
);
   logic [CHANNELS-1:0][WIDTH-1:0] cnt;
   logic [CHANNELS-1:0]            reached, hit, wrap, at_max;

   // One independent lane per channel; no shared state between lanes.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      multi_channel_threshold_counter_lane #(
         .WIDTH(WIDTH), .THRESHOLD(THRESHOLD), .MAX_COUNT(MAX_COUNT)
      ) u_lane (
         .clock_i      (clock_i),
         .clear_n_i    (clear_n_i),
         .enable_i     (bus.enable[i]),
         .recycle_i    (bus.recycle[i]),
         .load_i       (bus.load[i]),
         .load_value_i (bus.load_value[i*WIDTH +: WIDTH]),
         .count_o      (cnt[i]),
         .reached_o    (reached[i]),
         .hit_pulse_o  (hit[i]),
         .wrap_pulse_o (wrap[i]),
         .at_max_o     (at_max[i])
      );
   end

   assign bus.count      = cnt;
   assign bus.reached    = reached;
   assign bus.hit_pulse  = hit;
   assign bus.wrap_pulse = wrap;
   assign bus.at_max     = at_max;
endmodule

// File: tb/tb_multi_channel_threshold_counter.sv
// Directed bench: default single channel (A), WIDTH=4/MAX=9 clamp (B),
// and a three-channel independence run (C).
module tb_multi_channel_threshold_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr_a, clr_b, clr_c;
   int   checks = 0;
   int   failures = 0;

   multi_channel_threshold_counter_if #(.CHANNELS(1), .WIDTH(3)) bus_a ();
   multi_channel_threshold_counter_if #(.CHANNELS(1), .WIDTH(4)) bus_b ();
   multi_channel_threshold_counter_if #(.CHANNELS(3), .WIDTH(3)) bus_c ();

   multi_channel_threshold_counter #(.CHANNELS(1), .WIDTH(3), .THRESHOLD(4), .MAX_COUNT(7))
      dut_a (.clock_i(clk), .clear_n_i(clr_a), .bus(bus_a));
   multi_channel_threshold_counter #(.CHANNELS(1), .WIDTH(4), .THRESHOLD(4), .MAX_COUNT(9))
      dut_b (.clock_i(clk), .clear_n_i(clr_b), .bus(bus_b));
   multi_channel_threshold_counter #(.CHANNELS(3), .WIDTH(3), .THRESHOLD(4), .MAX_COUNT(7))
      dut_c (.clock_i(clk), .clear_n_i(clr_c), .bus(bus_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // flags packed as {reached, hit_pulse, wrap_pulse, at_max}
   task automatic test_reset();
      clr_a = 0; bus_a.enable = 1; bus_a.load = 1; bus_a.load_value = 3'd5;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (bus_a.count !== 3'd0) begin
            failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", k, bus_a.count);
         end
         checks++;
         if ({bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags cyc=%0d got=%b exp=0000", k,
                     {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max});
         end
      end
      bus_a.load = 0;
   endtask

   task automatic test_saturate();
      logic [2:0] ec;
      logic [3:0] ef;
      clr_a = 1; bus_a.enable = 1; bus_a.recycle = 0; bus_a.load = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         ec = (k > 7) ? 3'd7 : 3'(k);
         ef = {ec >= 3'd4, k == 4, 1'b0, ec == 3'd7};
         checks++;
         if (bus_a.count !== ec) begin
            failures++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, bus_a.count, ec);
         end
         checks++;
         if ({bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== ef) begin
            failures++;
            $display("FAIL sat_flags k=%0d got=%b exp=%b", k,
                     {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max}, ef);
         end
      end
   endtask

   task automatic test_recycle();
      logic [2:0] ec [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      logic [3:0] ef [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1000, 4'b1000,
                              4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
      clr_a = 0; step(); clr_a = 1;
      bus_a.enable = 1; bus_a.recycle = 1; bus_a.load = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         checks++;
         if (bus_a.count !== ec[k]) begin
            failures++; $display("FAIL rec_count k=%0d got=%0d exp=%0d", k, bus_a.count, ec[k]);
         end
         checks++;
         if ({bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== ef[k]) begin
            failures++;
            $display("FAIL rec_flags k=%0d got=%b exp=%b", k,
                     {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max}, ef[k]);
         end
      end
      bus_a.recycle = 0;
   endtask

   task automatic test_load();
      bus_a.enable = 0; bus_a.load = 1; bus_a.load_value = 3'd5;
      step();
      checks++;
      if ({bus_a.count, bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== {3'd5, 4'b1000}) begin
         failures++; $display("FAIL load5 got cnt=%0d flags=%b exp cnt=5 flags=1000", bus_a.count,
                              {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max});
      end
      bus_a.load_value = 3'd2;
      step();
      checks++;
      if ({bus_a.count, bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== {3'd2, 4'b0000}) begin
         failures++; $display("FAIL load2 got cnt=%0d flags=%b exp cnt=2 flags=0000", bus_a.count,
                              {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max});
      end
      bus_a.load = 0;
   endtask

   task automatic test_load_priority();
      clr_a = 0; step(); clr_a = 1;
      bus_a.enable = 1; bus_a.load = 0;
      repeat (3) step();
      checks++;
      if (bus_a.count !== 3'd3) begin
         failures++; $display("FAIL prio_pre got=%0d exp=3", bus_a.count);
      end
      bus_a.load = 1; bus_a.load_value = 3'd4;
      step();
      checks++;
      if ({bus_a.count, bus_a.reached, bus_a.hit_pulse} !== {3'd4, 2'b10}) begin
         failures++; $display("FAIL prio_load got cnt=%0d r=%b h=%b exp cnt=4 r=1 h=0",
                              bus_a.count, bus_a.reached, bus_a.hit_pulse);
      end
      bus_a.load = 0;
      step();
      checks++;
      if ({bus_a.count, bus_a.reached, bus_a.hit_pulse} !== {3'd5, 2'b10}) begin
         failures++; $display("FAIL prio_after got cnt=%0d r=%b h=%b exp cnt=5 r=1 h=0",
                              bus_a.count, bus_a.reached, bus_a.hit_pulse);
      end
   endtask

   task automatic test_clamp();
      clr_b = 0; step(); clr_b = 1;
      bus_b.load = 1; bus_b.load_value = 4'd15; bus_b.enable = 0; bus_b.recycle = 0;
      step();
      checks++;
      if ({bus_b.count, bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max} !== {4'd9, 4'b1001}) begin
         failures++; $display("FAIL clamp got cnt=%0d flags=%b exp cnt=9 flags=1001", bus_b.count,
                              {bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max});
      end
      bus_b.load = 0; bus_b.enable = 1;
      step();
      checks++;
      if ({bus_b.count, bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max} !== {4'd9, 4'b1001}) begin
         failures++; $display("FAIL clamp_hold got cnt=%0d flags=%b exp cnt=9 flags=1001", bus_b.count,
                              {bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max});
      end
      bus_b.recycle = 1;
      step();
      checks++;
      if ({bus_b.count, bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max} !== {4'd0, 4'b0010}) begin
         failures++; $display("FAIL clamp_wrap got cnt=%0d flags=%b exp cnt=0 flags=0010", bus_b.count,
                              {bus_b.reached, bus_b.hit_pulse, bus_b.wrap_pulse, bus_b.at_max});
      end
   endtask

   task automatic test_clear_mid();
      logic [2:0] en_pat [5] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
      logic [2:0] ec     [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
      bus_a.enable = 0; bus_a.load = 1; bus_a.load_value = 3'd5;
      step();
      clr_a = 0; bus_a.enable = 1; bus_a.load = 1; bus_a.load_value = 3'd6;
      step();
      checks++;
      if ({bus_a.count, bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max} !== 7'd0) begin
         failures++; $display("FAIL clear_mid got cnt=%0d flags=%b exp all 0", bus_a.count,
                              {bus_a.reached, bus_a.hit_pulse, bus_a.wrap_pulse, bus_a.at_max});
      end
      clr_a = 1; bus_a.load = 0;
      for (int k = 0; k < 5; k++) begin
         bus_a.enable = en_pat[k][0];
         step();
         checks++;
         if (bus_a.count !== ec[k]) begin
            failures++; $display("FAIL en_toggle k=%0d got=%0d exp=%0d", k, bus_a.count, ec[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      // ch0 saturating, ch1 recycling, ch2 loaded with 1 on cycle 5
      int c0 [10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
      int c1 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
      int c2 [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6};
      int prev [3] = '{0, 0, 0};
      int ec;
      logic [3:0] ef;
      logic [2:0] got;
      clr_c = 0; bus_c.enable = 0; bus_c.load = 0; bus_c.recycle = 0; bus_c.load_value = '0;
      step();
      clr_c = 1; bus_c.enable = 3'b111; bus_c.recycle = 3'b010;
      bus_c.load_value = {3'd1, 3'd6, 3'd5};
      for (int k = 1; k <= 10; k++) begin
         bus_c.load = (k == 5) ? 3'b100 : 3'b000;
         step();
         for (int i = 0; i < 3; i++) begin
            ec  = (i == 0) ? c0[k-1] : (i == 1) ? c1[k-1] : c2[k-1];
            ef  = {ec >= 4, ec == 4 && prev[i] == 3, ec == 0 && prev[i] == 7, ec == 7};
            got = bus_c.count[i*3 +: 3];
            checks++;
            if (got !== 3'(ec)) begin
               failures++; $display("FAIL multi_count k=%0d ch=%0d got=%0d exp=%0d", k, i, got, ec);
            end
            checks++;
            if ({bus_c.reached[i], bus_c.hit_pulse[i], bus_c.wrap_pulse[i], bus_c.at_max[i]} !== ef) begin
               failures++;
               $display("FAIL multi_flags k=%0d ch=%0d got=%b exp=%b", k, i,
                        {bus_c.reached[i], bus_c.hit_pulse[i], bus_c.wrap_pulse[i], bus_c.at_max[i]}, ef);
            end
            prev[i] = ec;
         end
      end
   endtask

   initial begin
      clr_a = 0; clr_b = 0; clr_c = 0;
      bus_a.enable = 0; bus_a.recycle = 0; bus_a.load = 0; bus_a.load_value = '0;
      bus_b.enable = 0; bus_b.recycle = 0; bus_b.load = 0; bus_b.load_value = '0;
      bus_c.enable = 0; bus_c.recycle = 0; bus_c.load = 0; bus_c.load_value = '0;
      test_reset();
      test_saturate();
      test_recycle();
      test_load();
      test_load_priority();
      test_clamp();
      test_clear_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
